// File: rtl/prog_loader.sv
`default_nettype none
// prog_loader: framed byte-stream boot loader. Fills the core's program memory from
// SYNC/LEN/payload/CHK frames, verifies the checksum and releases the core reset on success.
module prog_loader #(
    parameter int         MEM_DEPTH = 32,
    parameter int         ADDR_W    = 5,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 1000,
    parameter int         TO_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_CSUM  = 3'd3,
        S_CHECK = 3'd4,
        S_RUN   = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [7:0]      DEPTH_B = 8'(MEM_DEPTH);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam bit              TO_EN   = (TIMEOUT != 0);

    state_t              state_q, state_d;
    logic [7:0]          rem_q, rem_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          sum_q, sum_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                accept;

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        addr_d      = addr_q;
        sum_d       = sum_q;
        to_d        = '0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;

        unique case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_d = S_LEN;
                    err_d   = 1'b0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if ((in_data != 8'd0) && (in_data <= DEPTH_B)) begin
                        state_d = S_DATA;
                        rem_d   = in_data;
                        addr_d  = '0;
                        sum_d   = '0;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_DATA: begin
                // SYNC_BYTE is plain payload here: no mid-frame resync.
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                    addr_d      = addr_q + ADDR_W'(1);
                    sum_d       = sum_q + in_data;
                    rem_d       = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    sum_d   = sum_q + in_data;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = (sum_q == 8'd0) ? S_RUN : S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An accepted byte always wins over an expiring idle counter.
        if ((state_q inside {S_LEN, S_DATA, S_CSUM}) && !accept) begin
            to_d = to_q + TO_W'(1);
            if (TO_EN && (to_q == TO_LAST)) begin
                state_d = S_ERR;
            end
        end

        if (state_d == S_ERR) begin
            err_d = 1'b1;
        end

        in_ready_d  = (state_d != S_CHECK);
        cpu_rst_n_d = (state_d == S_RUN);
        busy_d      = (state_d inside {S_LEN, S_DATA, S_CSUM, S_CHECK});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            addr_q      <= '0;
            sum_q       <= '0;
            to_q        <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            addr_q      <= addr_d;
            sum_q       <= sum_d;
            to_q        <= to_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
`default_nettype wire
